// File: rtl/axil_reg_responder.sv
// AXI-lite register responder: word-addressed bank with a read-only ID at index 0
// and read/write registers above it; register 1 is exported as ctrl_out.
module axil_reg_responder #(
  parameter int              DW       = 32,
  parameter int              AW       = 32,
  parameter int              NREGS    = 8,
  parameter logic [DW-1:0]   ID_VALUE = 32'hACE0_0001
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [AW-1:0]     awaddr,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [AW-1:0]     araddr,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [DW-1:0]     ctrl_out
);

  localparam int IW = $clog2(NREGS);
  localparam int NB = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ~|a[AW-1:IW+2];
  endfunction

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  logic          aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, wr_ok;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;

  always_comb begin
    aw_hs   = awvalid && awready_q;
    w_hs    = wvalid && wready_q;
    ar_hs   = arvalid && arready_q;
    b_hs    = bvalid_q && bready;
    r_hs    = rvalid_q && rready;

    // A channel captured in this cycle supplies its live bus value, otherwise the held copy.
    wr_addr = aw_hs ? awaddr : awaddr_q;
    wr_data = w_hs ? wdata : wdata_q;
    wr_strb = w_hs ? wstrb : wstrb_q;
    wr_idx  = wr_addr[IW+1:2];
    wr_ok   = in_range(wr_addr) && (wr_idx != '0);
    commit  = (aw_hs && (w_hs || w_held_q)) || (w_hs && aw_held_q);

    regs_d   = regs_q;
    awaddr_d = wr_addr;
    wdata_d  = wr_data;
    wstrb_d  = wr_strb;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        for (int k = 0; k < NB; k++) begin
          if (wr_strb[k]) regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    // Held flags persist through the response phase so both readies stay low until bready.
    aw_held_d = b_hs ? 1'b0 : (aw_hs || aw_held_q);
    w_held_d  = b_hs ? 1'b0 : (w_hs || w_held_q);
    awready_d = !aw_held_d;
    wready_d  = !w_held_d;

    rd_idx   = araddr[IW+1:2];
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (!in_range(araddr)) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = (rd_idx == '0) ? ID_VALUE : regs_q[rd_idx];
        rresp_d = RESP_OKAY;
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  // Held payloads are only consulted while their flag is set, so they need no reset.
  always_ff @(posedge aclk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign ctrl_out = regs_q[1];

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, wr_addr[1:0], araddr[1:0]};

endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI-lite subordinate (responder) that terminates the AXI_lite interface driven by masters and bench write/read tasks.
- Implements a small word-addressed register bank:
  - index 0: read-only ID.
  - indices 1..NREGS-1: read/write scratch/control registers.
  - Register 1 is exported as a control output.
- One write and one read outstanding at most. Write and read channels are independent.

Parameters:
- DW, 32, data width. Only 32 is supported.
- AW, 32, address width.
- NREGS, 8, number of registers. Power of 2, at least 2.
- ID_VALUE, 32'hACE0_0001, constant returned by register 0.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- awaddr  in  AW  write address
- awprot  in  3  ignored
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DW  write data
- wstrb  in  DW/8  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  AW  read address
- arprot  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DW  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- ctrl_out  out  DW  current value of register 1

Behaviour:
- Reset (aresetn low at a posedge):
  - All outputs go to 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, ctrl_out.
  - Registers 1..NREGS-1 clear to 0.
  - Any captured AW/W/AR state is discarded; no response is issued for it.
  - At the first posedge with aresetn high, awready, wready and arready go to 1.
- Address decode:
  - idx = addr[2+log2(NREGS)-1 : 2]. Bits [1:0] are ignored.
  - Any set bit in addr[AW-1 : 2+log2(NREGS)] is out of range.
- Write path (AW and W captured independently):
  - Held-address flag set on awvalid&awready; awready drops the next cycle.
  - Held-data flag set on wvalid&wready; wready drops the next cycle.
  - Order is free: AW first, W first, or both in the same cycle.
  - Commit happens at the posedge where the second of the two is captured, or where both are captured together. Data used is the live bus value in that cycle, or the held value if captured earlier.
  - At the commit edge:
    - For each byte lane k with wstrb[k]=1, reg[idx] byte k <= wdata byte k.
    - bvalid <= 1.
    - bresp <= OKAY (00).
  - Error cases, commit still completes:
    - idx==0: no write, bresp=SLVERR (10).
    - Out of range: no write, bresp=SLVERR.
  - Hold phase: bvalid, bresp, awready=0 and wready=0 stay stable until bvalid&bready.
  - On that edge: bvalid <= 0; awready <= 1 and wready <= 1, clearing both held flags.
  - Latency: both handshakes at edge N puts bvalid high at edge N (visible in cycle N+1). With bready held 1, the next write is accepted in cycle N+2.
  - ctrl_out equals reg[1] and updates on the commit edge.
- Read path:
  - On arvalid&arready:
    - arready <= 0; rvalid <= 1.
    - idx 0: rdata <= ID_VALUE, rresp <= OKAY.
    - Valid idx: rdata <= reg[idx], rresp <= OKAY.
    - Out of range: rdata <= 0, rresp <= SLVERR.
  - rdata and rresp stay stable while rvalid=1 and rready=0.
  - On rvalid&rready: rvalid <= 0, arready <= 1.
- Simultaneous events:
  - Read handshake at the same edge as a write commit to the same idx returns the pre-write value.
  - Write and read channels never stall each other.
- wstrb=0: valid write with no register change; bresp=OKAY.

Test Plan:
- Reset, ID read and reset values:
  - Release reset, read 0x00 -> rdata=32'hACE0_0001, rresp=00.
  - Read 0x04 -> 0, and ctrl_out=0.
- Full write and readback:
  - Write data=32'hDEADBEEF, addr=0x04, strb=4'hF, AW and W in the same cycle -> bvalid one cycle later, bresp=00, ctrl_out=32'hDEADBEEF.
  - Read 0x04 -> 32'hDEADBEEF.
- Byte strobes and channel ordering:
  - Write 0x11223344 to 0x08 with strb=4'hF.
  - Present W data 0xAABBCCDD with strb=4'b0101 three cycles before AW 0x08.
  - Read 0x08 -> 32'h11BB33DD.
- Error responses:
  - Write to 0x00 -> bresp=10, ID unchanged.
  - Write to 0x40 -> bresp=10.
  - Read 0x40 -> rresp=10, rdata=0.
- Backpressure:
  - Hold bready=0 for 5 cycles after a commit -> bvalid and bresp stable; awready and wready stay 0; a second AW is not accepted until the bready handshake.
  - Same check for rready=0 with arready held 0.
- Reset mid-transaction:
  - Capture AW only, assert aresetn=0 for one cycle -> no bvalid, registers cleared.
  - After release, a fresh write to 0x0C completes with OKAY.
